// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and helper functions.
package uart_pkg;

  localparam int unsigned STATE_W       = 3;
  localparam int unsigned MAX_DATA_BITS = 9;

  // Frame state encoding, shared by the transmitter and receiver.
  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY_S = 3'd3,
    STOP     = 3'd4
  } uart_state_t;

  // Parity mode strings accepted by the PARITY parameter.
  localparam string PAR_NONE = "none";
  localparam string PAR_EVEN = "even";
  localparam string PAR_ODD  = "odd";

  // Clock cycles per bit (truncating division).
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Parity bit for a zero-extended payload; odd_mode selects odd parity.
  function automatic logic par_bit(input logic [MAX_DATA_BITS-1:0] data,
                                   input logic                     odd_mode);
    return (^data) ^ odd_mode;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int unsigned DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_count;

  assign o_tick_c = (r_count == CNT_W'(DIV - 1));

  // Count cycles within a bit; clear on restart and at every bit boundary.
  always_ff @(posedge clk) begin
    if (rst || i_restart || o_tick_c) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_trans.sv
// UART transmitter: accepts bytes on an AXI-Stream slave port and serialises
// them as start, DATA_BITS data bits LSB first, optional parity, stop.
module uart_trans
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter string       PARITY    = "even"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int unsigned BAUD_DIV     = baud_div(CLK_FREQ, BAUD);
  localparam bit          HAS_PAR      = (PARITY != PAR_NONE);
  localparam logic        PAR_ODD_MODE = (PARITY == PAR_ODD);
  localparam int unsigned CNT_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  uart_state_t            r_state;
  logic [DATA_BITS-1:0]   r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_par;
  logic                   r_tx;
  logic                   r_busy;

  uart_state_t            w_state_next;
  logic [DATA_BITS-1:0]   w_shift_next;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_par_next;
  logic                   w_tx_next;
  logic                   w_handshake;
  logic                   w_restart;
  logic                   w_tick;

  assign s_axis_tready = (r_state == IDLE) && !rst;
  assign w_handshake   = s_axis_tvalid && s_axis_tready;
  assign tx            = r_tx;
  assign tx_busy       = r_busy;

  // Hold the bit timer at zero while idle and restart it on every state entry.
  assign w_restart = (r_state == IDLE) || (w_state_next != r_state);

  uart_baud_gen #(
    .DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .o_tick_c  (w_tick)
  );

  // Next-state, shift and line-level decode; tx follows the next state so the
  // line changes on the same edge as the state.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_bit_cnt;
    w_par_next   = r_par;
    w_tx_next    = 1'b1;

    case (r_state)
      IDLE: begin
        if (w_handshake) begin
          w_state_next = START;
          w_shift_next = s_axis_tdata;
          w_par_next   = par_bit(MAX_DATA_BITS'(s_axis_tdata), PAR_ODD_MODE);
          w_cnt_next   = '0;
        end
      end
      START: begin
        if (w_tick) w_state_next = DATA;
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == CNT_W'(DATA_BITS - 1)) begin
            w_cnt_next   = '0;
            w_state_next = HAS_PAR ? PARITY_S : STOP;
          end else begin
            w_cnt_next   = r_bit_cnt + CNT_W'(1);
            w_shift_next = r_shift >> 1;
          end
        end
      end
      PARITY_S: begin
        if (w_tick) w_state_next = STOP;
      end
      STOP: begin
        if (w_tick) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    case (w_state_next)
      START:    w_tx_next = 1'b0;
      DATA:     w_tx_next = w_shift_next[0];
      PARITY_S: w_tx_next = w_par_next;
      default:  w_tx_next = 1'b1;
    endcase
  end

  // State, datapath and output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_cnt_next;
      r_par     <= w_par_next;
      r_tx      <= w_tx_next;
      r_busy    <= (w_state_next != IDLE);
    end
  end

endmodule
